// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences one single-ported unified memory between the fetch requester
//   (IF stage) and the load/store requester (MEM stage). One access is in
//   flight at a time. Ties are broken round-robin, and a timeout guards
//   against a memory that never asserts mem_ready.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   if_req/if_addr        fetch request, held until if_valid
//   if_rdata/if_valid     fetched word and its one-cycle valid pulse
//   if_stall              if_req && !if_valid (combinational)
//   d_req/d_we/d_addr/
//   d_wdata               load/store request, held until d_valid
//   d_rdata/d_valid       load data and its one-cycle completion pulse
//   d_stall               d_req && !d_valid (combinational)
//   mem_en/mem_we/
//   mem_addr/mem_wdata    registered memory command
//   mem_rdata/mem_ready   memory read data and completion strobe
//   bus_err               sticky timeout flag, cleared only by rst
//
// Optional build macro ARB_PERF_CNT_EN
//   Adds perf_if_stall/perf_d_stall: 32-bit saturating counts of the cycles
//   in which the matching stall output is high.

module mem_port_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] FETCH_FILL     = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_stall
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  state_t            state_q, state_d;
  logic              last_fetch_q, last_fetch_d;  // 1: last grant went to fetch
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              bus_err_q, bus_err_d;

  logic              grant_data;
  logic [CNT_W-1:0]  cnt_inc;

  // Data wins when it is alone, or on a tie when fetch had the last grant.
  assign grant_data = d_req && (!if_req || last_fetch_q);
  // Saturating increment; the counter never wraps.
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    cnt_d        = cnt_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    bus_err_d    = bus_err_q;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d      = D_BUSY;
          last_fetch_d = 1'b0;
          cnt_d        = '0;
          mem_en_d     = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
        end else if (if_req) begin
          state_d      = I_BUSY;
          last_fetch_d = 1'b1;
          cnt_d        = '0;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
        end
      end

      D_BUSY, I_BUSY: begin
        if (mem_ready) begin
          // A ready on the timeout edge still counts as a normal completion.
          if (state_q == D_BUSY) begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            // Abort: hand the owner a harmless result so the pipeline moves on.
            if (state_q == D_BUSY) begin
              if (!mem_we_q) d_rdata_d = '0;
              d_valid_d = 1'b1;
            end else begin
              if_rdata_d = FETCH_FILL;
              if_valid_d = 1'b1;
            end
            bus_err_d = 1'b1;
            mem_en_d  = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_fetch_q <= 1'b1;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign bus_err   = bus_err_q;
  assign if_stall  = if_req && !if_valid_q;
  assign d_stall   = d_req && !d_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q;
  logic [31:0] perf_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      if (if_stall && (perf_if_q != 32'hFFFF_FFFF)) perf_if_q <= perf_if_q + 1'b1;
      if (d_stall && (perf_d_q != 32'hFFFF_FFFF))   perf_d_q  <= perf_d_q + 1'b1;
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_d_stall  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, if_stall, d_valid, d_stall;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        bus_err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_d_stall;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .FETCH_FILL(32'h0000_0013)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody, 1 = data, 2 = fetch. waited = busy edges without ready.
  int          owner;
  int          waited;
  bit          last_fetch;
  logic        m_en, m_we, m_if_valid, m_d_valid, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  logic [31:0] m_pif, m_pd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = 0; waited = 0; last_fetch = 1'b1;
      m_en = 0; m_we = 0; m_if_valid = 0; m_d_valid = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
      m_pif = 0; m_pd = 0;
    end else begin
      if (if_req && !m_if_valid && m_pif != 32'hFFFF_FFFF) m_pif = m_pif + 1;
      if (d_req && !m_d_valid && m_pd != 32'hFFFF_FFFF)    m_pd  = m_pd + 1;
      m_if_valid = 0;
      m_d_valid  = 0;
      if (owner == 0) begin
        if (d_req && (!if_req || last_fetch)) begin
          owner = 1; last_fetch = 0; waited = 0;
          m_en = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        end else if (if_req) begin
          owner = 2; last_fetch = 1; waited = 0;
          m_en = 1; m_we = 0; m_addr = if_addr;
        end
      end else begin
        if (!mem_ready) waited = waited + 1;
        if (mem_ready || waited == TO) begin
          if (owner == 1) begin
            if (!m_we) m_d_rdata = mem_ready ? mem_rdata : 32'h0;
            m_d_valid = 1;
          end else begin
            m_if_rdata = mem_ready ? mem_rdata : 32'h0000_0013;
            m_if_valid = 1;
          end
          if (!mem_ready) m_err = 1;
          owner = 0; m_en = 0; m_we = 0;
        end
      end
    end
  end

  // ---------------- memory responder (stimulus) ----------------
  // lat = busy cycle in which ready rises (0 = never). Ready is high in idle
  // to show that it is ignored there.
  int          lat = 1;
  logic [31:0] rd_val = 32'h0;

  always @(posedge clk) begin
    #2;
    mem_rdata = rd_val;
    if (owner == 0) mem_ready = 1'b1;
    else            mem_ready = (lat != 0) && (waited + 1 >= lat);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("mem_en", mem_en, m_en);
    if (rst || m_en) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (rst || m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_valid", if_valid, m_if_valid);
    chk("d_valid", d_valid, m_d_valid);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("bus_err", bus_err, m_err);
    chk("if_stall", if_stall, if_req && !m_if_valid);
    chk("d_stall", d_stall, d_req && !m_d_valid);
`ifdef ARB_PERF_CNT_EN
    chk("perf_if_stall", perf_if_stall, m_pif);
    chk("perf_d_stall", perf_d_stall, m_pd);
`endif
  end

  // Wait for the next valid pulse; report who completed, busy-cycle count,
  // and the command seen on the first busy cycle.
  task automatic wait_any(output int who, output int busy,
                          output logic [31:0] a0, output logic w0);
    who = 0; busy = 0; a0 = 'x; w0 = 1'bx;
    for (int i = 0; i < 60 && who == 0; i++) begin
      @(negedge clk); #1;
      if (mem_en) begin
        if (busy == 0) begin a0 = mem_addr; w0 = mem_we; end
        busy++;
      end
      if (d_valid)       who = 1;
      else if (if_valid) who = 2;
    end
    chk("valid_within_bound", 64'(who != 0), 64'd1);
    $display("txn: %s done after %0d busy cycles, addr=%0h we=%0b",
             (who == 1) ? "data" : (who == 2) ? "fetch" : "none", busy, a0, w0);
  endtask

  int          who, busy;
  logic [31:0] a0;
  logic        w0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 0;

    // Single load, ready on the first busy cycle.
    rd_val = 32'hDEAD_BEEF; lat = 1;
    d_we = 0; d_addr = 32'h40; d_req = 1;
    wait_any(who, busy, a0, w0);
    chk("load_who", who, 1);
    chk("load_addr", a0, 32'h40);
    chk("load_we", w0, 0);
    chk("load_busy", busy, 1);
    chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("load_stall_at_valid", d_stall, 0);
    d_req = 0;

    // Store with 3-cycle latency; load data must not change.
    rd_val = 32'h5555_AAAA; lat = 3;
    d_we = 1; d_wdata = 32'h1234_5678; d_addr = 32'h80; d_req = 1;
    wait_any(who, busy, a0, w0);
    chk("store_who", who, 1);
    chk("store_we", w0, 1);
    chk("store_busy", busy, 3);
    chk("store_keeps_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 0; d_we = 0;

    // Fetch that times out, then a good fetch: bus_err stays set.
    lat = 0; if_addr = 32'h100; if_req = 1;
    wait_any(who, busy, a0, w0);
    chk("to_who", who, 2);
    chk("to_busy", busy, 16);
    chk("to_fill", if_rdata, 32'h0000_0013);
    chk("to_bus_err", bus_err, 1);
    if_req = 0;
    @(negedge clk); #1;
    lat = 1; rd_val = 32'h00A0_0093; if_addr = 32'h104; if_req = 1;
    wait_any(who, busy, a0, w0);
    chk("fetch2_rdata", if_rdata, 32'h00A0_0093);
    chk("bus_err_sticky", bus_err, 1);
    if_req = 0;

    // Reset, then hold both requests: order data, fetch, data, fetch.
    @(negedge clk); #1; rst = 1;
    @(negedge clk); #1;
    chk("rst_clears_err", bus_err, 0);
    rst = 0;
    lat = 2; d_we = 0; d_addr = 32'h200; if_addr = 32'h300; rd_val = 32'h1000;
    d_req = 1; if_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_any(who, busy, a0, w0);
      chk("tie_order", who, (k % 2 == 0) ? 1 : 2);
      if (who == 1) d_addr = d_addr + 4; else if_addr = if_addr + 4;
      rd_val = rd_val + 32'h11;
    end
    d_req = 0; if_req = 0;
    @(negedge clk); #1;

    // Reset in the middle of a data access.
    lat = 0; d_we = 0; d_addr = 32'h400; d_req = 1;
    repeat (3) @(negedge clk);
    #1; rst = 1; #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_d_valid", d_valid, 0);
    @(negedge clk); #1;
    rst = 0; lat = 1; rd_val = 32'hCAFE_0001; if_req = 1;
    wait_any(who, busy, a0, w0);
    chk("post_rst_tie", who, 1);
    chk("post_rst_rdata", d_rdata, 32'hCAFE_0001);
    d_req = 0;
    wait_any(who, busy, a0, w0);
    chk("post_rst_fetch", who, 2);
    if_req = 0;
    repeat (2) @(negedge clk);

`ifdef ARB_PERF_CNT_EN
    #1; rst = 1; #1;
    chk("perf_if_rst", perf_if_stall, 0);
    chk("perf_d_rst", perf_d_stall, 0);
    @(negedge clk); #1; rst = 0;
    repeat (2) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
